// File: rtl/pll_clkgen_mc_if.sv
// Divider configuration handshake for pll_clkgen_mc: the controller drives
// valid/ch/div and the clock generator returns ready.
interface pll_clkgen_mc_if #(
   parameter int CH_W  = 2,
   parameter int DIV_W = 8
);
   logic             valid;
   logic             ready;
   logic [CH_W-1:0]  ch;
   logic [DIV_W-1:0] div;

   modport master (output valid, ch, div, input ready);
   modport slave  (input valid, ch, div, output ready);
endinterface

// File: rtl/pll_clkgen_mc.sv
// Multi-channel PLL clock generator model: per-channel integer dividers of CLK_VCO,
// a lock FSM that relocks after every reconfiguration, and FREF bypass.
// Optional FREF loss monitor is enabled by defining PLL_CLKGEN_FREF_MON_EN.
module pll_clkgen_mc #(
   parameter int NUM_CH       = 4,
   parameter int DIV_W        = 8,
   parameter int LOCK_CYCLES  = 64,
   parameter int DEF_DIV      = 2,
   parameter int FREF_TIMEOUT = 1024
) (
   input  logic                clk_vco,
   input  logic                RESETN,
   input  logic                fref,
   input  logic                bypass,
   pll_clkgen_mc_if.slave      cfg,
   output logic [NUM_CH-1:0]   clko,
   output logic                lock
);
   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int CHV_W = CH_W + 1;
   localparam int LC_W  = $clog2(LOCK_CYCLES + 1);
   localparam logic [CHV_W-1:0] NUM_CH_V  = CHV_W'(NUM_CH);
   localparam logic [LC_W-1:0]  LOCK_LAST = LC_W'(LOCK_CYCLES - 1);
   localparam logic [DIV_W-1:0] DIV_MIN   = DIV_W'(2);
   localparam logic [DIV_W-1:0] DIV_DEF   = DIV_W'(DEF_DIV);

   typedef enum logic [0:0] {
      LOCKING = 1'b0,
      LOCKED  = 1'b1
   } state_t;

   state_t            state_r;
   state_t            state_nxt_s;
   logic [LC_W-1:0]   lock_cnt_r;
   logic [LC_W-1:0]   lock_cnt_nxt_s;
   logic [DIV_W-1:0]  div_r [NUM_CH];
   logic [DIV_W-1:0]  cnt_r [NUM_CH];
   logic [NUM_CH-1:0] clk_r;
   logic              accept_s;
   logic              wr_hit_s;
   logic              timeout_s;
   logic              run_s;
   logic [DIV_W-1:0]  div_eff_s;

   // High-phase length ceil(d/2), computed one bit wider so d = 2^DIV_W-1 cannot overflow.
   function automatic logic [DIV_W-1:0] half_up(input logic [DIV_W-1:0] d);
      logic [DIV_W:0] sum;
      sum = {1'b0, d} + {{DIV_W{1'b0}}, 1'b1};
      return sum[DIV_W:1];
   endfunction

   assign lock      = (state_r == LOCKED);
   assign cfg.ready = (state_r == LOCKED);
   assign accept_s  = cfg.valid & cfg.ready;
   assign wr_hit_s  = accept_s & ({1'b0, cfg.ch} < NUM_CH_V);
   assign div_eff_s = (cfg.div < DIV_MIN) ? DIV_MIN : cfg.div;
   // Counters only advance when staying LOCKED, so every relock restarts all channels in phase.
   assign run_s     = (state_r == LOCKED) && (state_nxt_s == LOCKED);
   assign clko      = bypass ? {NUM_CH{fref}} : clk_r;

`ifdef PLL_CLKGEN_FREF_MON_EN
   localparam int TO_W = $clog2(FREF_TIMEOUT + 1);
   localparam logic [TO_W-1:0] TO_MAX = TO_W'(FREF_TIMEOUT);

   logic [2:0]      fref_sync_r;
   logic [TO_W-1:0] tmo_r;
   logic            fref_edge_s;

   assign fref_edge_s = fref_sync_r[1] & ~fref_sync_r[2];
   assign timeout_s   = (tmo_r >= TO_MAX);

   // FREF synchroniser and saturating time-since-last-edge counter.
   always_ff @(posedge clk_vco) begin
      if (!RESETN) begin
         fref_sync_r <= 3'b000;
         tmo_r       <= {TO_W{1'b0}};
      end else begin
         fref_sync_r <= {fref_sync_r[1:0], fref};
         if (fref_edge_s || ((state_r == LOCKED) && (state_nxt_s == LOCKING))) begin
            tmo_r <= {TO_W{1'b0}};
         end else if (tmo_r != TO_MAX) begin
            tmo_r <= tmo_r + TO_W'(1);
         end else begin
            tmo_r <= tmo_r;
         end
      end
   end
`else
   logic unused_fref_to_s;

   assign timeout_s        = 1'b0;
   assign unused_fref_to_s = (FREF_TIMEOUT > 0);
`endif

   // Lock state register.
   always_ff @(posedge clk_vco) begin
      if (!RESETN) begin
         state_r    <= LOCKING;
         lock_cnt_r <= {LC_W{1'b0}};
      end else begin
         state_r    <= state_nxt_s;
         lock_cnt_r <= lock_cnt_nxt_s;
      end
   end

   // Lock sequencing: count out LOCK_CYCLES, then hold until a config hit or FREF loss.
   always_comb begin
      state_nxt_s    = state_r;
      lock_cnt_nxt_s = lock_cnt_r;
      case (state_r)
         LOCKING: begin
            if (lock_cnt_r == LOCK_LAST) begin
               state_nxt_s    = LOCKED;
               lock_cnt_nxt_s = {LC_W{1'b0}};
            end else begin
               lock_cnt_nxt_s = lock_cnt_r + LC_W'(1);
            end
         end
         LOCKED: begin
            if (wr_hit_s || timeout_s) begin
               state_nxt_s    = LOCKING;
               lock_cnt_nxt_s = {LC_W{1'b0}};
            end else begin
               state_nxt_s    = LOCKED;
            end
         end
         default: begin
            state_nxt_s    = LOCKING;
            lock_cnt_nxt_s = {LC_W{1'b0}};
         end
      endcase
   end

   // Per-channel divider registers, phase counters and registered clock outputs.
   always_ff @(posedge clk_vco) begin
      if (!RESETN) begin
         for (int i = 0; i < NUM_CH; i++) begin
            div_r[i] <= DIV_DEF;
            cnt_r[i] <= {DIV_W{1'b0}};
         end
         clk_r <= {NUM_CH{1'b0}};
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (wr_hit_s && (cfg.ch == CH_W'(i))) begin
               div_r[i] <= div_eff_s;
            end else begin
               div_r[i] <= div_r[i];
            end
            if (run_s) begin
               cnt_r[i] <= (cnt_r[i] == (div_r[i] - DIV_W'(1))) ? {DIV_W{1'b0}}
                                                                : (cnt_r[i] + DIV_W'(1));
               clk_r[i] <= (cnt_r[i] < half_up(div_r[i]));
            end else begin
               cnt_r[i] <= {DIV_W{1'b0}};
               clk_r[i] <= 1'b0;
            end
         end
      end
   end
endmodule
